// File: rtl/gs_dac_latch.sv
// General Sound DAC/volume latch: captures Z80 writes and applies them on 64-cycle frame boundaries.
// Optional build macro GS_VOL_RAMP_EN: volumes slew one step per frame toward their target.
module gs_dac_latch #(
    parameter logic [7:0]  DAC_RESET      = 8'h80,
    parameter int unsigned FRAME_LEN_LOG2 = 6
) (
    input  logic        clk32,
    input  logic        rst_n,
    input  logic [15:0] ga,
    input  logic [7:0]  gd,
    input  logic        n_gwr,
    input  logic        n_gmreq,
    input  logic        n_giorq,
    output logic [7:0]  dac0,
    output logic [7:0]  dac1,
    output logic [7:0]  dac2,
    output logic [7:0]  dac3,
    output logic [5:0]  vol0,
    output logic [5:0]  vol1,
    output logic [5:0]  vol2,
    output logic [5:0]  vol3,
    output logic        frame_tick
);

    localparam int unsigned NCH = 4;
    localparam int unsigned DW  = 8;
    localparam int unsigned VW  = 6;
    localparam int unsigned FW  = FRAME_LEN_LOG2;
    localparam logic [FW-1:0] CNT_LAST = '1;
    localparam logic [FW-1:0] CNT_PRE  = CNT_LAST - FW'(1);

    typedef enum logic {
        CLEAN = 1'b0,
        DIRTY = 1'b1
    } ch_state_e;

    logic            wr_n_c;
    logic [2:0]      wr_sync;
    logic            wr_evt_c;
    logic            dac_wr_c;
    logic            vol_wr_c;
    logic [1:0]      dac_ch_c;
    logic [1:0]      vol_ch_c;
    logic            apply_c;
    logic [FW-1:0]   frame_cnt;
    logic [DW-1:0]   dac_q    [NCH];
    logic [VW-1:0]   vol_q    [NCH];
    logic [DW-1:0]   pend_dac [NCH];
    logic [VW-1:0]   pend_vol [NCH];
    ch_state_e       state    [NCH];
    logic            unused_ga_c;

    assign wr_n_c      = n_gwr | (n_gmreq & n_giorq);
    assign unused_ga_c = ^ga[12:10];

    // Two-stage synchroniser plus one delay stage for falling-edge detection
    always_ff @(posedge clk32 or negedge rst_n) begin
        if (!rst_n) begin
            wr_sync <= 3'b111;
        end else begin
            wr_sync <= {wr_sync[1:0], wr_n_c};
        end
    end

    assign wr_evt_c = wr_sync[2] & ~wr_sync[1];

    // Address/data are held by the Z80 for the whole strobe, so they are sampled directly
    always_comb begin
        dac_wr_c = wr_evt_c & ~n_gmreq & (ga[15:13] == 3'b011);
        dac_ch_c = ga[9:8];
        vol_wr_c = wr_evt_c & ~n_giorq & (ga[7:4] == 4'h0)
                 & (ga[3:0] >= 4'd6) & (ga[3:0] <= 4'd9);
        vol_ch_c = 2'(ga[3:0] - 4'd6);
    end

    // Updates land on the same edge that raises frame_tick
    assign apply_c = (frame_cnt == CNT_PRE);

`ifdef GS_VOL_RAMP_EN
    logic [VW-1:0] vol_step_c [NCH];

    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            vol_step_c[i] = vol_q[i];
            if (vol_q[i] < pend_vol[i]) begin
                vol_step_c[i] = vol_q[i] + VW'(1);
            end else if (vol_q[i] > pend_vol[i]) begin
                vol_step_c[i] = vol_q[i] - VW'(1);
            end
        end
    end
`endif

    // A write in the apply cycle wins over the CLEAN transition, keeping the channel dirty
    always_ff @(posedge clk32 or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt  <= '0;
            frame_tick <= 1'b0;
            for (int i = 0; i < NCH; i++) begin
                dac_q[i]    <= DAC_RESET;
                vol_q[i]    <= '0;
                pend_dac[i] <= DAC_RESET;
                pend_vol[i] <= '0;
                state[i]    <= CLEAN;
            end
        end else begin
            frame_cnt  <= frame_cnt + FW'(1);
            frame_tick <= apply_c;
            for (int i = 0; i < NCH; i++) begin
                if (apply_c && state[i] == DIRTY) begin
                    dac_q[i] <= pend_dac[i];
`ifdef GS_VOL_RAMP_EN
                    vol_q[i] <= vol_step_c[i];
                    if (vol_step_c[i] == pend_vol[i]) begin
                        state[i] <= CLEAN;
                    end
`else
                    vol_q[i] <= pend_vol[i];
                    state[i] <= CLEAN;
`endif
                end
                if (dac_wr_c && dac_ch_c == 2'(i)) begin
                    pend_dac[i] <= gd;
                    state[i]    <= DIRTY;
                end
                if (vol_wr_c && vol_ch_c == 2'(i)) begin
                    pend_vol[i] <= gd[VW-1:0];
                    state[i]    <= DIRTY;
                end
            end
        end
    end

    assign dac0 = dac_q[0];
    assign dac1 = dac_q[1];
    assign dac2 = dac_q[2];
    assign dac3 = dac_q[3];
    assign vol0 = vol_q[0];
    assign vol1 = vol_q[1];
    assign vol2 = vol_q[2];
    assign vol3 = vol_q[3];

endmodule

// File: tb/tb_gs_dac_latch.sv
// Self-checking bench for gs_dac_latch: directed scenarios plus random bus writes against a frame-level model.
`timescale 1ns/1ps
module tb_gs_dac_latch;

    logic        clk32   = 1'b0;
    logic        rst_n   = 1'b0;
    logic [15:0] ga      = 16'h0000;
    logic [7:0]  gd      = 8'h00;
    logic        n_gwr   = 1'b1;
    logic        n_gmreq = 1'b1;
    logic        n_giorq = 1'b1;
    logic [7:0]  dac0, dac1, dac2, dac3;
    logic [5:0]  vol0, vol1, vol2, vol3;
    logic        frame_tick;

    gs_dac_latch dut (
        .clk32      (clk32),
        .rst_n      (rst_n),
        .ga         (ga),
        .gd         (gd),
        .n_gwr      (n_gwr),
        .n_gmreq    (n_gmreq),
        .n_giorq    (n_giorq),
        .dac0       (dac0),
        .dac1       (dac1),
        .dac2       (dac2),
        .dac3       (dac3),
        .vol0       (vol0),
        .vol1       (vol1),
        .vol2       (vol2),
        .vol3       (vol3),
        .frame_tick (frame_tick)
    );

    always #15.625 clk32 = ~clk32;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: cycles counted since reset release; a tick every cycle where count mod 64 == 63
    int          cyc      = 0;
    int          m_dac[4] = '{8'h80, 8'h80, 8'h80, 8'h80};
    int          m_vol[4] = '{0, 0, 0, 0};
    int          p_dac[4] = '{8'h80, 8'h80, 8'h80, 8'h80};
    int          p_vol[4] = '{0, 0, 0, 0};
    bit          m_dirty[4] = '{0, 0, 0, 0};
    int          pw_edge  = -1;
    logic [15:0] pw_ga    = 16'h0;
    logic [7:0]  pw_gd    = 8'h0;
    bit          pw_mreq  = 1'b0;
    bit          pw_iorq  = 1'b0;

    always @(posedge clk32 or negedge rst_n) begin
        if (!rst_n) begin
            cyc = 0;
            for (int c = 0; c < 4; c++) begin
                m_dac[c] = 8'h80; m_vol[c] = 0;
                p_dac[c] = 8'h80; p_vol[c] = 0;
                m_dirty[c] = 1'b0;
            end
        end else begin
            cyc++;
            if (cyc % 64 == 63) begin
                for (int c = 0; c < 4; c++) begin
                    if (m_dirty[c]) begin
                        m_dac[c] = p_dac[c];
`ifdef GS_VOL_RAMP_EN
                        if (m_vol[c] < p_vol[c]) m_vol[c] = m_vol[c] + 1;
                        else if (m_vol[c] > p_vol[c]) m_vol[c] = m_vol[c] - 1;
                        m_dirty[c] = (m_vol[c] != p_vol[c]);
`else
                        m_vol[c] = p_vol[c];
                        m_dirty[c] = 1'b0;
`endif
                    end
                end
            end
            if (cyc == pw_edge) begin
                int a;
                int port;
                a = int'(pw_ga);
                port = a % 16;
                if (pw_mreq && (a / 8192) == 3) begin
                    p_dac[(a / 256) % 4] = int'(pw_gd);
                    m_dirty[(a / 256) % 4] = 1'b1;
                end else if (pw_iorq && ((a / 16) % 16) == 0 && port >= 6 && port <= 9) begin
                    p_vol[port - 6] = int'(pw_gd) % 64;
                    m_dirty[port - 6] = 1'b1;
                end
            end
        end
    end

    always @(negedge clk32) begin
        if (chk_en) begin
            check("dac0", dac0, m_dac[0]);
            check("dac1", dac1, m_dac[1]);
            check("dac2", dac2, m_dac[2]);
            check("dac3", dac3, m_dac[3]);
            check("vol0", vol0, m_vol[0]);
            check("vol1", vol1, m_vol[1]);
            check("vol2", vol2, m_vol[2]);
            check("vol3", vol3, m_vol[3]);
            check("frame_tick", frame_tick, (rst_n && cyc % 64 == 63));
        end
    end

    // Callers sit 2 ns after a rising edge
    task automatic step(input int n);
        repeat (n) @(posedge clk32);
        #2;
    endtask

    task automatic align(input int phase);
        for (int k = 0; k < 64 && (cyc % 64) != phase; k++) step(1);
        check("align", cyc % 64, phase);
    endtask

    // 125 ns strobe; the write reaches pending three edges after the strobe falls
    task automatic bus_write(input bit mem, input logic [15:0] a, input logic [7:0] d);
        ga = a; gd = d;
        n_gmreq = ~mem; n_giorq = mem;
        n_gwr = 1'b0;
        pw_ga = a; pw_gd = d; pw_mreq = mem; pw_iorq = ~mem;
        pw_edge = cyc + 3;
        step(4);
        n_gwr = 1'b1;
        step(1);
        n_gmreq = 1'b1; n_giorq = 1'b1;
        pw_edge = -1;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, fails);
        $fatal(1);
    end

    initial begin
        int first;
        logic [15:0] a;
        first = -1;
        step(3);
        chk_en = 1'b1;
        rst_n = 1'b1;
        check("rst_dac0", dac0, 8'h80);
        check("rst_vol3", vol3, 6'h00);

        for (int k = 0; k < 100; k++) begin
            step(1);
            if (frame_tick) begin
                first = cyc;
                break;
            end
        end
        check("first_tick_cycle", first, 63);

        bus_write(1'b1, 16'h6100, 8'h3C);
        align(63);
        check("dac1_write", dac1, 8'h3C);
        check("dac0_untouched", dac0, 8'h80);

        bus_write(1'b0, 16'h0008, 8'hFF);
        align(63);
`ifdef GS_VOL_RAMP_EN
        check("vol2_ramp_first", vol2, 6'h01);
        for (int k = 0; k < 62; k++) begin
            step(1);
            align(63);
        end
`endif
        check("vol2_final", vol2, 6'h3F);

        step(1);
        bus_write(1'b1, 16'h6000, 8'h10);
        bus_write(1'b1, 16'h60FF, 8'hF0);
        align(63);
        check("dac0_last_wins", dac0, 8'hF0);

        align(60);
        bus_write(1'b1, 16'h6300, 8'h5A);
        check("coincident_hold", dac3, 8'h80);
        align(63);
        check("coincident_applied", dac3, 8'h5A);

        step(1);
        bus_write(1'b1, 16'h4000, 8'h11);
        bus_write(1'b0, 16'h0005, 8'h22);
        align(63);
        check("ignored_dac0", dac0, 8'hF0);
        check("ignored_vol0", vol0, 6'h00);

        step(1);
        bus_write(1'b1, 16'h6200, 8'h77);
        step(7);
        pulse_reset();
        check("midreset_dac3", dac3, 8'h80);
        check("midreset_vol2", vol2, 6'h00);
        align(63);
        check("midreset_pending_lost", dac2, 8'h80);

        for (int it = 0; it < 200; it++) begin
            int kind;
            kind = $urandom_range(0, 9);
            step($urandom_range(0, 40));
            if (kind < 4) begin
                a = 16'($urandom);
                a[15:13] = 3'b011;
                bus_write(1'b1, a, 8'($urandom));
            end else if (kind < 8) begin
                a = 16'($urandom) & 16'hFF00;
                a = a | 16'($urandom_range(6, 9));
                bus_write(1'b0, a, 8'($urandom));
            end else if (kind == 8) begin
                bus_write($urandom_range(0, 1) == 1, 16'($urandom), 8'($urandom));
            end else if (it % 40 == 0) begin
                pulse_reset();
            end
        end

        step(140);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
